// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage CPU.
// Covers what forwarding cannot resolve: load-use stalls, taken-branch
// flushes, data-memory wait freezes, and the HLT drain/halt sequence.
// All enables and flushes are combinational from the current state and
// inputs; state, drain counter, halted flag and stall counter are flops.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ifidRs,
  input  logic [3:0]       ifidRt,
  input  logic             ifidUsesRs,
  input  logic             ifidUsesRt,
  input  logic             idexMemRead,
  input  logic [3:0]       idexWR,
  input  logic             br_taken_EX,
  input  logic             halt_ID,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             lu;

  // Load-use hazard; register 0 is hardwired and never conflicts.
  assign lu = idexMemRead && (idexWR != 4'd0) &&
              ((ifidUsesRs && (ifidRs == idexWR)) ||
               (ifidUsesRt && (ifidRt == idexWR)));

  // Next-state logic and combinational pipeline controls.
  always_comb begin
    // NOTE: every output and next-state value gets a default first so no
    // path through the case/if tree can leave it unassigned (no latches).
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    state_d     = state_q;
    dcnt_d      = dcnt_q;

    unique case (state_q)
      S_RUN: begin
        if (dmem_busy) begin
          // Memory wait freezes the front of the pipe and bubbles MEM/WB.
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
        end else if (br_taken_EX) begin
          // Squash the two younger instructions; PC takes the target.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (lu) begin
          // One bubble: the load reaches MEM next cycle and forwards.
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (halt_ID) begin
          // HLT moves into ID/EX; nothing younger is fetched.
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          state_d    = S_DRAIN;
          dcnt_d     = DW'(DRAIN_CYCLES);
        end
      end

      S_DRAIN: begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
        if (dmem_busy) begin
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
        end else if (br_taken_EX) begin
          // An older taken branch cancels the HLT and resumes fetch.
          pc_en      = 1'b1;
          idex_flush = 1'b1;
          state_d    = S_RUN;
          dcnt_d     = '0;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
          if (dcnt_q <= DW'(1)) begin
            state_d = S_HALTED;
            dcnt_d  = '0;
          end
        end
      end

      S_HALTED: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        memwb_flush = 1'b1;
      end

      default: begin
        state_d = S_RUN;
        dcnt_d  = '0;
      end
    endcase

    // While reset is held the pipe runs with its plain defaults.
    if (rst) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
    end

    halted_d = (state_d == S_HALTED);

    // Saturating count of stalled cycles outside HALTED.
    stall_d = stall_q;
    if (!pc_en && (state_q != S_HALTED) && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
  end

  // State, drain counter, halted flag and stall counter registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= S_RUN;
      dcnt_q   <= '0;
      halted_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      halted_q <= halted_d;
      stall_q  <= stall_d;
    end
  end

  assign halted       = halted_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. A 16-bit-counter instance covers the
// functional scenarios; a 4-bit-counter instance shares the same stimulus
// and covers counter saturation.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ifidRs, ifidRt, idexWR;
  logic        ifidUsesRs, ifidUsesRt, idexMemRead;
  logic        br_taken_EX, halt_ID, dmem_busy;

  logic        pc_en, ifid_en, idex_en, exmem_en;
  logic        ifid_flush, idex_flush, memwb_flush, halted;
  logic [15:0] stall_cycles;

  logic        s4_pc_en, s4_ifid_en, s4_idex_en, s4_exmem_en;
  logic        s4_ifid_flush, s4_idex_flush, s4_memwb_flush, s4_halted;
  logic [3:0]  s4_stall_cycles;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_stall;

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush}
  wire  [6:0]  ctl  = {pc_en, ifid_en, idex_en, exmem_en,
                       ifid_flush, idex_flush, memwb_flush};
  wire  [6:0]  ctl4 = {s4_pc_en, s4_ifid_en, s4_idex_en, s4_exmem_en,
                       s4_ifid_flush, s4_idex_flush, s4_memwb_flush};

  localparam logic [6:0] CTL_RUN       = 7'b1111_000;
  localparam logic [6:0] CTL_LU        = 7'b0011_010;
  localparam logic [6:0] CTL_BR        = 7'b1111_110;
  localparam logic [6:0] CTL_FRZ       = 7'b0000_001;
  localparam logic [6:0] CTL_HLT_ID    = 7'b0111_100;
  localparam logic [6:0] CTL_DRAIN     = 7'b0111_100;
  localparam logic [6:0] CTL_DRAIN_FRZ = 7'b0000_101;
  localparam logic [6:0] CTL_HALTED    = 7'b0000_111;

  hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ifidRs(ifidRs), .ifidRt(ifidRt),
    .ifidUsesRs(ifidUsesRs), .ifidUsesRt(ifidUsesRt),
    .idexMemRead(idexMemRead), .idexWR(idexWR),
    .br_taken_EX(br_taken_EX), .halt_ID(halt_ID), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .ifidRs(ifidRs), .ifidRt(ifidRt),
    .ifidUsesRs(ifidUsesRs), .ifidUsesRt(ifidUsesRt),
    .idexMemRead(idexMemRead), .idexWR(idexWR),
    .br_taken_EX(br_taken_EX), .halt_ID(halt_ID), .dmem_busy(dmem_busy),
    .pc_en(s4_pc_en), .ifid_en(s4_ifid_en), .idex_en(s4_idex_en),
    .exmem_en(s4_exmem_en), .ifid_flush(s4_ifid_flush),
    .idex_flush(s4_idex_flush), .memwb_flush(s4_memwb_flush),
    .halted(s4_halted), .stall_cycles(s4_stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    ifidRs = 4'd0; ifidRt = 4'd0; idexWR = 4'd0;
    ifidUsesRs = 1'b0; ifidUsesRt = 1'b0; idexMemRead = 1'b0;
    br_taken_EX = 1'b0; halt_ID = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic set_lu(input logic [3:0] wr);
    idexMemRead = 1'b1; idexWR = wr; ifidRs = wr; ifidUsesRs = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    exp_stall = 16'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Defaults while reset is held, even with a load-use pattern present.
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    set_lu(4'd5);
    halt_ID = 1'b1;
    #2;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_RUN); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted_held: got %b want 0", halted); end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    exp_stall = 16'd0;
  endtask

  task automatic test_load_use();
    // Rs match on a load: one-cycle stall.
    @(negedge clk); set_lu(4'd5); #1;
    checks++; if (ctl !== CTL_LU) begin errors++; $display("FAIL lu_rs_ctl: got %b want %b", ctl, CTL_LU); end
    @(posedge clk); #1; exp_stall = exp_stall + 16'd1;
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL lu_rs_stall: got %0d want %0d", stall_cycles, exp_stall); end
    // Load has moved on: no stall.
    @(negedge clk); clear_inputs(); #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_after_ctl: got %b want %b", ctl, CTL_RUN); end
    // Destination r0 never stalls.
    @(negedge clk); set_lu(4'd0); #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_r0_ctl: got %b want %b", ctl, CTL_RUN); end
    // Rt match only counts when Rt is used.
    @(negedge clk); clear_inputs(); idexMemRead = 1'b1; idexWR = 4'd7; ifidRt = 4'd7; #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_rt_unused_ctl: got %b want %b", ctl, CTL_RUN); end
    ifidUsesRt = 1'b1; #1;
    checks++; if (ctl !== CTL_LU) begin errors++; $display("FAIL lu_rt_ctl: got %b want %b", ctl, CTL_LU); end
    // Non-load with a match: no stall.
    idexMemRead = 1'b0; #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_noload_ctl: got %b want %b", ctl, CTL_RUN); end
    idexMemRead = 1'b1;
    @(posedge clk); #1; exp_stall = exp_stall + 16'd1;
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL lu_rt_stall: got %0d want %0d", stall_cycles, exp_stall); end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); clear_inputs(); set_lu(4'(3 + i)); #1;
      checks++; if (ctl !== CTL_LU) begin errors++; $display("FAIL b2b_ctl%0d: got %b want %b", i, ctl, CTL_LU); end
      @(posedge clk); #1; exp_stall = exp_stall + 16'd1;
    end
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL b2b_stall: got %0d want %0d", stall_cycles, exp_stall); end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_branch_wins();
    @(negedge clk); set_lu(4'd9); br_taken_EX = 1'b1; halt_ID = 1'b1; #1;
    checks++; if (ctl !== CTL_BR) begin errors++; $display("FAIL br_ctl: got %b want %b", ctl, CTL_BR); end
    @(posedge clk); #1;
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL br_stall: got %0d want %0d", stall_cycles, exp_stall); end
    @(negedge clk); clear_inputs(); #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL br_after_ctl: got %b want %b (halt not squashed)", ctl, CTL_RUN); end
  endtask

  task automatic test_mem_freeze();
    @(negedge clk); set_lu(4'd6); br_taken_EX = 1'b1; dmem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (ctl !== CTL_FRZ) begin errors++; $display("FAIL frz_ctl%0d: got %b want %b", i, ctl, CTL_FRZ); end
      @(posedge clk); #1; exp_stall = exp_stall + 16'd1;
    end
    @(negedge clk); dmem_busy = 1'b0; #1;
    checks++; if (ctl !== CTL_BR) begin errors++; $display("FAIL frz_release_ctl: got %b want %b", ctl, CTL_BR); end
    @(posedge clk); #1;
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL frz_stall: got %0d want %0d", stall_cycles, exp_stall); end
    @(negedge clk); clear_inputs();
  endtask

  // Halt with optional freeze cycles in the first DRAIN cycles; then check
  // HALTED ignores a branch and asynchronous reset clears it.
  task automatic test_halt(input int busy_cycles);
    int last_edge;
    last_edge = 4 + busy_cycles;
    @(negedge clk); clear_inputs(); halt_ID = 1'b1; #1;
    checks++; if (ctl !== CTL_HLT_ID) begin errors++; $display("FAIL halt_id_ctl: got %b want %b", ctl, CTL_HLT_ID); end
    @(posedge clk); #1; exp_stall = exp_stall + 16'd1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_e1: got %b want 0", halted); end
    @(negedge clk); halt_ID = 1'b0;
    for (int e = 2; e <= last_edge; e++) begin
      if (e > 2) @(negedge clk);
      dmem_busy = (e - 2 < busy_cycles);
      #1;
      if (dmem_busy) begin
        checks++; if (ctl !== CTL_DRAIN_FRZ) begin errors++; $display("FAIL drain_frz_ctl e%0d: got %b want %b", e, ctl, CTL_DRAIN_FRZ); end
      end else begin
        checks++; if (ctl !== CTL_DRAIN) begin errors++; $display("FAIL drain_ctl e%0d: got %b want %b", e, ctl, CTL_DRAIN); end
      end
      @(posedge clk); #1; exp_stall = exp_stall + 16'd1;
      checks++; if (halted !== (e == last_edge)) begin errors++; $display("FAIL halt_e%0d: got %b want %b", e, halted, (e == last_edge)); end
    end
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL halt_stall: got %0d want %0d", stall_cycles, exp_stall); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); clear_inputs(); br_taken_EX = 1'b1; #1;
      checks++; if (ctl !== CTL_HALTED) begin errors++; $display("FAIL halted_ctl%0d: got %b want %b", i, ctl, CTL_HALTED); end
      @(posedge clk); #1;
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_hold%0d: got %b want 1", i, halted); end
    end
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL halted_stall: got %0d want %0d", stall_cycles, exp_stall); end
    // Asynchronous reset: effective without a clock edge.
    @(negedge clk); clear_inputs(); rst = 1'b1; #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL arst_halted: got %b want 0", halted); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL arst_stall: got %0d want 0", stall_cycles); end
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL arst_ctl: got %b want %b", ctl, CTL_RUN); end
    exp_stall = 16'd0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_halt_squash();
    @(negedge clk); clear_inputs(); halt_ID = 1'b1;
    @(posedge clk); #1; exp_stall = exp_stall + 16'd1;
    @(negedge clk); halt_ID = 1'b0; br_taken_EX = 1'b1; #1;
    checks++; if (ctl !== CTL_BR) begin errors++; $display("FAIL squash_ctl: got %b want %b", ctl, CTL_BR); end
    @(negedge clk); clear_inputs(); #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL squash_run_ctl: got %b want %b", ctl, CTL_RUN); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL squash_halted: got %b want 0", halted); end
    checks++; if (stall_cycles !== exp_stall) begin errors++; $display("FAIL squash_stall: got %0d want %0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_saturation();
    apply_reset();
    set_lu(4'd12);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 14) begin
        checks++; if (s4_stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_reach: got %0d want 15", s4_stall_cycles); end
      end
    end
    checks++; if (s4_stall_cycles !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", s4_stall_cycles); end
    checks++; if (stall_cycles !== 16'd20) begin errors++; $display("FAIL sat_wide: got %0d want 20", stall_cycles); end
    checks++; if (ctl4 !== CTL_LU || s4_halted !== 1'b0) begin errors++; $display("FAIL sat_ctl4: got %b/%b want %b/0", ctl4, s4_halted, CTL_LU); end
    @(negedge clk); clear_inputs();
  endtask

  initial begin
    exp_stall = 16'd0;
    test_reset();
    test_load_use();
    test_back_to_back();
    test_branch_wins();
    test_mem_freeze();
    test_halt(0);
    test_halt(2);
    test_halt_squash();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
